// File: rtl/mdu_iter_pkg.sv
// mdu_iter shared definitions: op codes, FSM state encodings, op helpers.
// Optional build macro: MDU_FAST_MULT_EN (single-pass multiply).
package mdu_iter_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_RUN  = 2'd1;
  localparam logic [1:0] MDU_FIX  = 2'd2;
  localparam logic [1:0] MDU_DONE = 2'd3;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter control/data bundle between the control unit and the MDU.
// master = control unit side, slave = MDU side.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement of a multiply or divide result.
// Multiply negates the full {hi,lo}; divide negates lo and hi independently.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             is_mul_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH-1:0]   lo_n;
  logic [WIDTH-1:0]   hi_n;

  assign prod   = {hi_i, lo_i};
  assign prod_n = -prod;
  assign lo_n   = -lo_i;
  assign hi_n   = -hi_i;

  // select negated or plain halves by op kind
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_mul_i) begin
      if (neg_q_i) begin
        {hi_o, lo_o} = prod_n;
      end
    end else begin
      if (neg_q_i) lo_o = lo_n;
      if (neg_r_i) hi_o = hi_n;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning HI/LO.
// `define MDU_FAST_MULT_EN makes MULT/MULTU skip the RUN iterations.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  mdu_iter_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   rhi_q, rhi_d;
  logic [WIDTH-1:0]   rlo_q, rlo_d;
  logic               mul_q, mul_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] raw;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign sgn   = op_is_signed(bus.op);
  assign abs_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // shift-add step: add multiplicand into the upper half on a set LSB
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // restoring step: trial subtract of divisor from shifted remainder
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, opnd_q};

  // unsigned magnitude result fed to the sign corrector
  always_comb begin
    raw = mul_q ? acc_q : {rem_q, acc_q[WIDTH-1:0]};
`ifdef MDU_FAST_MULT_EN
    if (mul_q) begin
      raw = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    end
`endif
  end

  mdu_sign_fix #(
    .WIDTH(WIDTH)
  ) u_fix (
    .is_mul_i(mul_q),
    .neg_q_i (negq_q),
    .neg_r_i (negr_q),
    .hi_i    (raw[2*WIDTH-1:WIDTH]),
    .lo_i    (raw[WIDTH-1:0]),
    .hi_o    (fix_hi),
    .lo_o    (fix_lo)
  );

  // next-state logic for the FSM and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    mul_d   = mul_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    busy_d  = busy_q && !done_q;
    done_d  = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (bus.start && !busy_q) begin
          unique case (bus.op)
            MDU_MTHI: hi_d = bus.a;
            MDU_MTLO: lo_d = bus.a;
            MDU_MULT, MDU_MULTU,
            MDU_DIV, MDU_DIVU: begin
              mul_d  = op_is_mul(bus.op);
              opnd_d = mul_d ? abs_a : abs_b;
              acc_d  = {{WIDTH{1'b0}}, (mul_d ? abs_b : abs_a)};
              rem_d  = '0;
              araw_d = bus.a;
              cnt_d  = CW'(WIDTH - 1);
              negq_d = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              negr_d = (bus.op == MDU_DIV) && bus.a[WIDTH-1];
              dz_d   = !mul_d && (bus.b == '0);
              busy_d = 1'b1;
              state_d = MDU_RUN;
`ifdef MDU_FAST_MULT_EN
              if (mul_d) state_d = MDU_FIX;
`endif
            end
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        if (mul_q) begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end else begin
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH],
                   acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end
        if (cnt_q == '0) begin
          state_d = MDU_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MDU_FIX: begin
        rhi_d   = dz_q ? araw_q : fix_hi;
        rlo_d   = dz_q ? {WIDTH{1'b1}} : fix_lo;
        state_d = MDU_DONE;
      end
      MDU_DONE: begin
        hi_d    = rhi_q;
        lo_d    = rlo_q;
        done_d  = 1'b1;
        state_d = MDU_IDLE;
`ifdef MDU_FAST_MULT_EN
        if (mul_q) busy_d = 1'b0;
`endif
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      mul_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      mul_q   <= mul_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors with a done-driven scoreboard.
// Honors MDU_FAST_MULT_EN for multiply latency expectations.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int LAT_MUL  = 2;
  localparam int BUSY_MUL = 2;
`else
  localparam int LAT_MUL  = W + 2;
  localparam int BUSY_MUL = W + 3;
`endif
  localparam int LAT_DIV  = W + 2;
  localparam int BUSY_DIV = W + 3;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   bcnt;
  exp_t sb[$];

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: pop expectation whenever done is presented
  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("done_cycle", W'(cyc), W'(e.due));
      end
    end
  end

  task automatic launch(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int lat,
                        input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.hi  = ehi;
    e.lo  = elo;
    e.due = cyc + 1 + lat;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_idle(input string name, input int exp_busy,
                           input int inj_at);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) begin
        ok = 1'b1;
        break;
      end
      bcnt++;
      if (bcnt == inj_at) begin
        bus.start = 1'b1;
        bus.op    = MDU_MTHI;
        bus.a     = 32'hDEADBEEF;
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd1, 32'd0);
    check({name, "_busy_cycles"}, W'(bcnt), W'(exp_busy));
  endtask

  initial begin
    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    bcnt = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(bus.busy), 32'd0);
    check("rst_done", W'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b1;

    launch(MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1,
           LAT_MUL, 1'b1);
    wait_idle("mult", BUSY_MUL, 0);
    launch(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
           32'h00000001, LAT_MUL, 1'b1);
    wait_idle("multu", BUSY_MUL, 0);
    launch(MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
           LAT_DIV, 1'b1);
    wait_idle("div", BUSY_DIV, 0);
    launch(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, LAT_DIV, 1'b1);
    wait_idle("divu", BUSY_DIV, 0);
    launch(MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, LAT_DIV, 1'b1);
    wait_idle("divu_z", BUSY_DIV, 0);
    launch(MDU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF,
           LAT_DIV, 1'b1);
    wait_idle("div_z", BUSY_DIV, 0);
    launch(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000,
           LAT_DIV, 1'b1);
    wait_idle("div_ovf", BUSY_DIV, 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_MTHI;
    bus.a     = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'h12345678);
    check("mthi_busy", W'(bus.busy), 32'd0);
    bus.op = MDU_MTLO;
    bus.a  = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    check("mtlo_hi", bus.hi, 32'h12345678);
    check("mtlo_busy", W'(bus.busy), 32'd0);
    check("mtlo_done", W'(bus.done), 32'd0);

    launch(MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
           LAT_DIV, 1'b1);
    wait_idle("div_inj", BUSY_DIV, 10);
    @(negedge clk);
    check("inj_hi_hold", bus.hi, 32'hFFFFFFFF);

    launch(MDU_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, LAT_DIV, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_busy", W'(bus.busy), 32'd0);
    check("abort_done", W'(bus.done), 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);

    launch(MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, LAT_MUL, 1'b1);
    wait_idle("multu_34", BUSY_MUL, 0);

    repeat (4) @(negedge clk);
    check("sb_empty", W'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
